// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: 1-cycle latency, flush > freeze > load, saturating bubble counter.
// Optional ID_EXE_FWD_EN adds src1/src2/two_src fields for the forwarding unit.
module id_exe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [3:0]            id_exe_cmd,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_wb_en,
    input  logic                  id_branch,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_op,
    input  logic [23:0]           id_simm24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic                  id_carry,
`ifdef ID_EXE_FWD_EN
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic                  exe_two_src,
`endif
    output logic                  exe_valid,
    output logic [DATA_W-1:0]     exe_pc,
    output logic [3:0]            exe_exe_cmd,
    output logic                  exe_mem_read,
    output logic                  exe_mem_write,
    output logic                  exe_wb_en,
    output logic                  exe_branch,
    output logic                  exe_s,
    output logic                  exe_imm,
    output logic [11:0]           exe_shift_op,
    output logic [23:0]           exe_simm24,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [DATA_W-1:0]     exe_val_rn,
    output logic [DATA_W-1:0]     exe_val_rm,
    output logic                  exe_carry,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic                  r_valid;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_wb_en;
    logic                  r_branch;
    logic                  r_s;
    logic [DATA_W-1:0]     r_pc;
    logic [3:0]            r_exe_cmd;
    logic                  r_imm;
    logic [11:0]           r_shift_op;
    logic [23:0]           r_simm24;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0]     r_val_rn;
    logic [DATA_W-1:0]     r_val_rm;
    logic                  r_carry;
    logic [CNT_W-1:0]      r_bubble_cnt;

    logic w_load;
    logic w_bubble;

    assign w_load   = ~flush & ~freeze;
    // A bubble is any edge that writes exe_valid to 0: flush, or loading an empty ID slot.
    assign w_bubble = flush | (w_load & ~id_valid);

    // Control bits are qualified by id_valid so exe_valid=0 always implies no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_valid, r_mem_read, r_mem_write, r_wb_en, r_branch, r_s} <= '0;
        end else if (flush) begin
            {r_valid, r_mem_read, r_mem_write, r_wb_en, r_branch, r_s} <= '0;
        end else if (!freeze) begin
            r_valid     <= id_valid;
            r_mem_read  <= id_valid & id_mem_read;
            r_mem_write <= id_valid & id_mem_write;
            r_wb_en     <= id_valid & id_wb_en;
            r_branch    <= id_valid & id_branch;
            r_s         <= id_valid & id_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_exe_cmd  <= '0;
            r_imm      <= 1'b0;
            r_shift_op <= '0;
            r_simm24   <= '0;
            r_dest     <= '0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_carry    <= 1'b0;
        end else if (flush) begin
            r_pc       <= '0;
            r_exe_cmd  <= '0;
            r_imm      <= 1'b0;
            r_shift_op <= '0;
            r_simm24   <= '0;
            r_dest     <= '0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_carry    <= 1'b0;
        end else if (!freeze) begin
            r_pc       <= id_pc;
            r_exe_cmd  <= id_exe_cmd;
            r_imm      <= id_imm;
            r_shift_op <= id_shift_op;
            r_simm24   <= id_simm24;
            r_dest     <= id_dest;
            r_val_rn   <= id_val_rn;
            r_val_rm   <= id_val_rm;
            r_carry    <= id_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

`ifdef ID_EXE_FWD_EN
    logic [REG_ADDR_W-1:0] r_src1;
    logic [REG_ADDR_W-1:0] r_src2;
    logic                  r_two_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src1    <= '0;
            r_src2    <= '0;
            r_two_src <= 1'b0;
        end else if (flush) begin
            r_src1    <= '0;
            r_src2    <= '0;
            r_two_src <= 1'b0;
        end else if (!freeze) begin
            r_src1    <= id_src1;
            r_src2    <= id_src2;
            r_two_src <= id_valid & id_two_src;
        end
    end

    assign exe_src1    = r_src1;
    assign exe_src2    = r_src2;
    assign exe_two_src = r_two_src;
`endif

    assign exe_valid     = r_valid;
    assign exe_pc        = r_pc;
    assign exe_exe_cmd   = r_exe_cmd;
    assign exe_mem_read  = r_mem_read;
    assign exe_mem_write = r_mem_write;
    assign exe_wb_en     = r_wb_en;
    assign exe_branch    = r_branch;
    assign exe_s         = r_s;
    assign exe_imm       = r_imm;
    assign exe_shift_op  = r_shift_op;
    assign exe_simm24    = r_simm24;
    assign exe_dest      = r_dest;
    assign exe_val_rn    = r_val_rn;
    assign exe_val_rm    = r_val_rm;
    assign exe_carry     = r_carry;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: directed vectors plus a per-cycle model compare (CNT_W 16 and 2).
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        br;
        logic        s;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        carry;
    } st_t;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    st_t         in_s;
    st_t         dut_s;
    st_t         sat_s;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;

    st_t         m;
    int unsigned mc16;
    int unsigned mc2;
    bit          cmp_en;
    int          checks;
    int          errors;

`ifdef ID_EXE_FWD_EN
    logic [3:0] fwd_src1, fwd_src2;
    logic       fwd_two;
    logic [3:0] d_src1, d_src2, s_src1, s_src2;
    logic       d_two, s_two;
    assign fwd_src1 = 4'h0;
    assign fwd_src2 = 4'h0;
    assign fwd_two  = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(in_s.valid), .id_pc(in_s.pc), .id_exe_cmd(in_s.cmd),
        .id_mem_read(in_s.mr), .id_mem_write(in_s.mw), .id_wb_en(in_s.wb),
        .id_branch(in_s.br), .id_s(in_s.s), .id_imm(in_s.imm),
        .id_shift_op(in_s.shop), .id_simm24(in_s.simm), .id_dest(in_s.dest),
        .id_val_rn(in_s.rn), .id_val_rm(in_s.rm), .id_carry(in_s.carry),
`ifdef ID_EXE_FWD_EN
        .id_src1(fwd_src1), .id_src2(fwd_src2), .id_two_src(fwd_two),
        .exe_src1(d_src1), .exe_src2(d_src2), .exe_two_src(d_two),
`endif
        .exe_valid(dut_s.valid), .exe_pc(dut_s.pc), .exe_exe_cmd(dut_s.cmd),
        .exe_mem_read(dut_s.mr), .exe_mem_write(dut_s.mw), .exe_wb_en(dut_s.wb),
        .exe_branch(dut_s.br), .exe_s(dut_s.s), .exe_imm(dut_s.imm),
        .exe_shift_op(dut_s.shop), .exe_simm24(dut_s.simm), .exe_dest(dut_s.dest),
        .exe_val_rn(dut_s.rn), .exe_val_rm(dut_s.rm), .exe_carry(dut_s.carry),
        .bubble_cnt(cnt16)
    );

    id_exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(in_s.valid), .id_pc(in_s.pc), .id_exe_cmd(in_s.cmd),
        .id_mem_read(in_s.mr), .id_mem_write(in_s.mw), .id_wb_en(in_s.wb),
        .id_branch(in_s.br), .id_s(in_s.s), .id_imm(in_s.imm),
        .id_shift_op(in_s.shop), .id_simm24(in_s.simm), .id_dest(in_s.dest),
        .id_val_rn(in_s.rn), .id_val_rm(in_s.rm), .id_carry(in_s.carry),
`ifdef ID_EXE_FWD_EN
        .id_src1(fwd_src1), .id_src2(fwd_src2), .id_two_src(fwd_two),
        .exe_src1(s_src1), .exe_src2(s_src2), .exe_two_src(s_two),
`endif
        .exe_valid(sat_s.valid), .exe_pc(sat_s.pc), .exe_exe_cmd(sat_s.cmd),
        .exe_mem_read(sat_s.mr), .exe_mem_write(sat_s.mw), .exe_wb_en(sat_s.wb),
        .exe_branch(sat_s.br), .exe_s(sat_s.s), .exe_imm(sat_s.imm),
        .exe_shift_op(sat_s.shop), .exe_simm24(sat_s.simm), .exe_dest(sat_s.dest),
        .exe_val_rn(sat_s.rn), .exe_val_rm(sat_s.rm), .exe_carry(sat_s.carry),
        .bubble_cnt(cnt2)
    );

    // Reference behaviour: flush empties the slot, freeze keeps it, otherwise take ID
    // with side-effect bits dropped for an empty slot; count every empty write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    = '0;
            mc16 = 0;
            mc2  = 0;
        end else begin
            bit bub;
            bub = 1'b0;
            if (flush) begin
                m   = '0;
                bub = 1'b1;
            end else if (!freeze) begin
                m = in_s;
                if (!in_s.valid) begin
                    m.mr = 1'b0; m.mw = 1'b0; m.wb = 1'b0; m.br = 1'b0; m.s = 1'b0;
                    bub  = 1'b1;
                end
            end
            if (bub) begin
                if (mc16 < 65535) mc16 = mc16 + 1;
                if (mc2 < 3)      mc2  = mc2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 1;
            if (dut_s !== m || sat_s !== m || cnt16 !== 16'(mc16) || cnt2 !== 2'(mc2)) begin
                errors = errors + 1;
                $display("FAIL model_cmp t=%0t actual=%h/%h cnt=%0d/%0d required=%h cnt=%0d/%0d",
                         $time, dut_s, sat_s, cnt16, cnt2, m, mc16, mc2);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        in_s   = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_fields", 64'(dut_s == '0), 64'd1);
        chk("reset_cnt", 64'(cnt16), 64'd0);
        cmp_en = 1'b1;

        // Basic load presented while still in reset
        in_s.valid = 1'b1; in_s.cmd = 4'b0010; in_s.wb = 1'b1;
        in_s.rn = 32'h5; in_s.dest = 4'h3;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("load_cmd", 64'(dut_s.cmd), 64'h2);
        chk("load_wb", 64'(dut_s.wb), 64'd1);
        chk("load_rn", 64'(dut_s.rn), 64'h5);
        chk("load_dest", 64'(dut_s.dest), 64'h3);
        chk("load_valid", 64'(dut_s.valid), 64'd1);

        // STR held through a 3-cycle freeze while ID keeps changing
        in_s = '0;
        in_s.valid = 1'b1; in_s.mw = 1'b1; in_s.rn = 32'hAAAA; in_s.dest = 4'h5; in_s.pc = 32'h100;
        step();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_s.rn = 32'hBBBB + 32'(i); in_s.dest = 4'h9; in_s.mw = 1'b0; in_s.wb = 1'b1;
            in_s.valid = (i != 1);
            step();
        end
        chk("freeze_mw", 64'(dut_s.mw), 64'd1);
        chk("freeze_rn", 64'(dut_s.rn), 64'hAAAA);
        chk("freeze_dest", 64'(dut_s.dest), 64'h5);
        chk("freeze_pc", 64'(dut_s.pc), 64'h100);
        chk("freeze_cnt", 64'(cnt16), 64'd0);

        // Flush wins over freeze on a valid LDR
        flush = 1'b1;
        in_s = '0;
        in_s.valid = 1'b1; in_s.mr = 1'b1; in_s.wb = 1'b1; in_s.rn = 32'h1234;
        in_s.pc = 32'h200; in_s.dest = 4'h2;
        step();
        chk("flush_valid", 64'(dut_s.valid), 64'd0);
        chk("flush_mr", 64'(dut_s.mr), 64'd0);
        chk("flush_wb", 64'(dut_s.wb), 64'd0);
        chk("flush_all_zero", 64'(dut_s == '0), 64'd1);
        chk("flush_cnt", 64'(cnt16), 64'd1);

        // Invalid load: side-effect bits dropped, data still copied
        flush = 1'b0; freeze = 1'b0;
        in_s = '0;
        in_s.wb = 1'b1; in_s.br = 1'b1; in_s.rn = 32'h7;
        step();
        chk("bubble_wb", 64'(dut_s.wb), 64'd0);
        chk("bubble_br", 64'(dut_s.br), 64'd0);
        chk("bubble_valid", 64'(dut_s.valid), 64'd0);
        chk("bubble_rn", 64'(dut_s.rn), 64'h7);
        chk("bubble_cnt", 64'(cnt16), 64'd2);

        // Reset asserted mid-cycle acts before the next edge
        in_s = '0;
        in_s.valid = 1'b1; in_s.wb = 1'b1; in_s.cmd = 4'h4; in_s.dest = 4'h1; in_s.rn = 32'd99;
        step();
        chk("pre_rst_valid", 64'(dut_s.valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fields", 64'(dut_s == '0), 64'd1);
        chk("async_rst_cnt", 64'(cnt16), 64'd0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(dut_s.valid), 64'd1);
        chk("post_rst_rn", 64'(dut_s.rn), 64'd99);
        chk("post_rst_cnt", 64'(cnt16), 64'd0);

        // Saturation of the 2-bit counter under back-to-back flushes
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_cnt2", 64'(cnt2), 64'(sat_exp[i]));
            chk("sat_cnt16", 64'(cnt16), 64'(i + 1));
        end
        flush = 1'b0;

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            in_s.valid = 1'($urandom_range(0, 3) != 0);
            in_s.pc    = $urandom;
            in_s.cmd   = 4'($urandom);
            in_s.mr    = 1'($urandom);
            in_s.mw    = 1'($urandom);
            in_s.wb    = 1'($urandom);
            in_s.br    = 1'($urandom);
            in_s.s     = 1'($urandom);
            in_s.imm   = 1'($urandom);
            in_s.shop  = 12'($urandom);
            in_s.simm  = 24'($urandom);
            in_s.dest  = 4'($urandom);
            in_s.rn    = $urandom;
            in_s.rm    = $urandom;
            in_s.carry = 1'($urandom);
            flush      = ($urandom_range(0, 5) == 0);
            freeze     = ($urandom_range(0, 3) == 0);
            step();
        end
        flush = 1'b0; freeze = 1'b0;
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
